// File: rtl/sb_trans_receiver_fsm_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sb_trans_receiver_fsm_if                               |
// | Description : Symbol input and decoded-field output bundle of the    |
// |               sideband transaction receiver.                         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface sb_trans_receiver_fsm_if;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_frame_err;
  logic        rx_enable;
  logic [2:0]  trans_type;
  logic        trans_valid;
  logic [7:0]  at_addr;
  logic        at_rw;
  logic [6:0]  at_len;
  logic [23:0] at_data;
  logic [7:0]  lt_lse;
  logic        crc_err;
  logic        parse_err;
  logic        busy;

  // Deserializer / control-unit side
  modport master (
    output rx_byte, rx_valid, rx_frame_err, rx_enable,
    input  trans_type, trans_valid, at_addr, at_rw, at_len, at_data,
           lt_lse, crc_err, parse_err, busy
  );

  // Receiver side
  modport slave (
    input  rx_byte, rx_valid, rx_frame_err, rx_enable,
    output trans_type, trans_valid, at_addr, at_rw, at_len, at_data,
           lt_lse, crc_err, parse_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/sb_trans_receiver_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sb_trans_receiver_fsm                                  |
// | Description : Sideband receive parser. Decodes LT (DLE-LSE-CLSE) and |
// |               AT (DLE-STX-addr-len-data-CRC-DLE-ETX) transactions,   |
// |               checks CRC-16 (0x8005) and framing, reports fields.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sb_trans_receiver_fsm #(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int MAX_DATA_BYTES = 3
) (
  input logic                    sb_clk,
  input logic                    rst,
  sb_trans_receiver_fsm_if.slave sb
);

  localparam logic [7:0] c_DLE     = 8'hFE;
  localparam logic [7:0] c_STX_CMD = 8'h05;
  localparam logic [7:0] c_STX_RSP = 8'h04;
  localparam logic [7:0] c_LSE     = 8'h80;
  localparam logic [7:0] c_ETX     = 8'h40;
  localparam int         c_TW      = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_DLE1, S_LT_CLSE, S_AT_ADDR, S_AT_LEN,
    S_AT_DATA, S_CRC_HI, S_CRC_LO, S_DLE2, S_ETX
  } state_t;

  state_t            r_state, w_state_n;
  logic [c_TW-1:0]   r_tmo;
  logic [15:0]       r_crc, r_rx_crc;
  logic              r_is_rsp;
  logic [7:0]        r_lse_sh, r_sh_addr;
  logic              r_sh_rw;
  logic [6:0]        r_sh_len, r_n, r_k;
  logic [23:0]       r_sh_data;

  logic [2:0]        r_trans_type;
  logic              r_trans_valid, r_crc_err, r_parse_err, r_busy;
  logic [7:0]        r_at_addr, r_lt_lse;
  logic              r_at_rw;
  logic [6:0]        r_at_len;
  logic [23:0]       r_at_data;

  logic              w_acc, w_good_lt, w_good_at, w_crc_bad, w_perr;
  logic [6:0]        w_n;
  logic [15:0]       w_crc_in, w_crc_next;

  // One CRC-16 byte step, MSB first, no reflection
  function automatic logic [15:0] f_crc8(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc ^ {d, 8'h00};
    for (int i = 0; i < 8; i++)
      c = c[15] ? ({c[14:0], 1'b0} ^ 16'h8005) : {c[14:0], 1'b0};
    return c;
  endfunction

  // A frame error always discards the byte it coincides with
  assign w_acc      = sb.rx_valid && sb.rx_enable && !sb.rx_frame_err;
  // A command read carries no data even though its length is non-zero
  assign w_n        = (r_is_rsp || sb.rx_byte[7]) ? sb.rx_byte[6:0] : 7'd0;
  // CRC restarts from all-ones when the STX byte is folded in
  assign w_crc_in   = (r_state == S_DLE1) ? 16'hFFFF : r_crc;
  assign w_crc_next = f_crc8(w_crc_in, sb.rx_byte);

  // State register
  always_ff @(posedge sb_clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_n;
  end

  // Next-state decode and end-of-transaction events
  always_comb begin
    w_state_n = r_state;
    w_good_lt = 1'b0;
    w_good_at = 1'b0;
    w_crc_bad = 1'b0;
    w_perr    = 1'b0;
    if (!sb.rx_enable) begin
      w_state_n = S_IDLE;
    end else if (sb.rx_frame_err && r_state != S_IDLE) begin
      w_perr    = 1'b1;
      w_state_n = S_IDLE;
    end else if (w_acc) begin
      case (r_state)
        S_IDLE:    if (sb.rx_byte == c_DLE) w_state_n = S_DLE1;
        S_DLE1: begin
          if (sb.rx_byte == c_STX_CMD || sb.rx_byte == c_STX_RSP) w_state_n = S_AT_ADDR;
          else if (sb.rx_byte == c_LSE) w_state_n = S_LT_CLSE;
          else begin
            w_perr    = 1'b1;
            w_state_n = S_IDLE;
          end
        end
        S_LT_CLSE: begin
          w_good_lt = (sb.rx_byte == ~r_lse_sh);
          w_perr    = (sb.rx_byte != ~r_lse_sh);
          w_state_n = S_IDLE;
        end
        S_AT_ADDR: w_state_n = S_AT_LEN;
        S_AT_LEN: begin
          if (w_n > 7'(MAX_DATA_BYTES)) begin
            w_perr    = 1'b1;
            w_state_n = S_IDLE;
          end else if (w_n == 7'd0) w_state_n = S_CRC_HI;
          else                      w_state_n = S_AT_DATA;
        end
        S_AT_DATA: if (r_k == r_n - 7'd1) w_state_n = S_CRC_HI;
        S_CRC_HI:  w_state_n = S_CRC_LO;
        S_CRC_LO:  w_state_n = S_DLE2;
        S_DLE2: begin
          if (sb.rx_byte == c_DLE) w_state_n = S_ETX;
          else begin
            w_perr    = 1'b1;
            w_state_n = S_IDLE;
          end
        end
        S_ETX: begin
          if (sb.rx_byte != c_ETX)    w_perr    = 1'b1;
          else if (r_rx_crc == r_crc) w_good_at = 1'b1;
          else                        w_crc_bad = 1'b1;
          w_state_n = S_IDLE;
        end
        default: w_state_n = S_IDLE;
      endcase
    end else if (r_state != S_IDLE && r_tmo == c_TW'(TIMEOUT_CYCLES - 1)) begin
      w_perr    = 1'b1;
      w_state_n = S_IDLE;
    end
  end

  // Inter-byte gap counter; cleared by every accepted byte and while idle
  always_ff @(posedge sb_clk or posedge rst) begin
    if (rst)                               r_tmo <= '0;
    else if (w_acc || w_state_n == S_IDLE) r_tmo <= '0;
    else                                   r_tmo <= r_tmo + 1'b1;
  end

  // Shadow capture of the transaction in flight and running CRC
  always_ff @(posedge sb_clk or posedge rst) begin
    if (rst) begin
      r_crc     <= '0;
      r_rx_crc  <= '0;
      r_is_rsp  <= 1'b0;
      r_lse_sh  <= '0;
      r_sh_addr <= '0;
      r_sh_rw   <= 1'b0;
      r_sh_len  <= '0;
      r_n       <= '0;
      r_k       <= '0;
      r_sh_data <= '0;
    end else if (w_acc) begin
      case (r_state)
        S_DLE1: begin
          r_crc    <= w_crc_next;
          r_is_rsp <= (sb.rx_byte == c_STX_RSP);
          r_lse_sh <= sb.rx_byte;
        end
        S_AT_ADDR: begin
          r_crc     <= w_crc_next;
          r_sh_addr <= sb.rx_byte;
        end
        S_AT_LEN: begin
          r_crc     <= w_crc_next;
          r_sh_rw   <= sb.rx_byte[7];
          r_sh_len  <= sb.rx_byte[6:0];
          r_n       <= w_n;
          r_k       <= '0;
          r_sh_data <= '0;
        end
        S_AT_DATA: begin
          r_crc     <= w_crc_next;
          r_sh_data <= r_sh_data | ({sb.rx_byte, 16'h0000} >> {r_k, 3'b000});
          r_k       <= r_k + 7'd1;
        end
        S_CRC_HI: r_rx_crc[15:8] <= sb.rx_byte;
        S_CRC_LO: r_rx_crc[7:0]  <= sb.rx_byte;
        default: ;
      endcase
    end
  end

  // Registered pulses, busy flag and field outputs (updated only on success)
  always_ff @(posedge sb_clk or posedge rst) begin
    if (rst) begin
      r_trans_type  <= '0;
      r_trans_valid <= 1'b0;
      r_crc_err     <= 1'b0;
      r_parse_err   <= 1'b0;
      r_busy        <= 1'b0;
      r_at_addr     <= '0;
      r_at_rw       <= 1'b0;
      r_at_len      <= '0;
      r_at_data     <= '0;
      r_lt_lse      <= '0;
    end else begin
      r_trans_valid <= w_good_lt | w_good_at;
      r_crc_err     <= w_crc_bad;
      r_parse_err   <= w_perr;
      r_busy        <= (w_state_n != S_IDLE);
      if (w_good_lt) begin
        r_trans_type <= 3'd4;
        r_lt_lse     <= r_lse_sh;
      end
      if (w_good_at) begin
        r_trans_type <= r_is_rsp ? 3'd3 : 3'd2;
        r_at_addr    <= r_sh_addr;
        r_at_rw      <= r_sh_rw;
        r_at_len     <= r_sh_len;
        r_at_data    <= r_sh_data;
      end
    end
  end

  assign sb.trans_type  = r_trans_type;
  assign sb.trans_valid = r_trans_valid;
  assign sb.crc_err     = r_crc_err;
  assign sb.parse_err   = r_parse_err;
  assign sb.busy        = r_busy;
  assign sb.at_addr     = r_at_addr;
  assign sb.at_rw       = r_at_rw;
  assign sb.at_len      = r_at_len;
  assign sb.at_data     = r_at_data;
  assign sb.lt_lse      = r_lt_lse;

endmodule
`default_nettype wire

// File: tb/tb_sb_trans_receiver_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_sb_trans_receiver_fsm                               |
// | Description : Self-checking bench: directed vector table, multi-     |
// |               cycle corner sequences and random frames checked       |
// |               against a frame-level reference model.                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_sb_trans_receiver_fsm;

  typedef struct packed {
    logic [2:0]  ttype;
    logic [7:0]  addr;
    logic        rw;
    logic [6:0]  len;
    logic [23:0] data;
    logic [7:0]  lse;
  } fields_t;

  typedef struct {
    logic [7:0] b [16];
    int         n;
    logic [2:0] pulse;   // {trans_valid, crc_err, parse_err} after last byte
    fields_t    f;       // field outputs after the frame
  } vec_t;

  logic sb_clk;
  logic rst;
  sb_trans_receiver_fsm_if sb ();

  sb_trans_receiver_fsm #(.TIMEOUT_CYCLES(40), .MAX_DATA_BYTES(3)) dut (
    .sb_clk (sb_clk),
    .rst    (rst),
    .sb     (sb)
  );

  initial sb_clk = 1'b0;
  always #5 sb_clk = ~sb_clk;

  int      n_pass  = 0;
  int      n_total = 0;
  fields_t exp_f;
  vec_t    tbl [10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  function automatic fields_t dut_fields();
    return {sb.trans_type, sb.at_addr, sb.at_rw, sb.at_len, sb.at_data, sb.lt_lse};
  endfunction

  // Bit-serial CRC-16/0x8005 over m[a..b]
  function automatic logic [15:0] ref_crc(input logic [7:0] m [16], input int a, input int b);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = a; i <= b; i++)
      for (int j = 7; j >= 0; j--) begin
        fb = c[15] ^ m[i][j];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    return c;
  endfunction

  function automatic vec_t mk(input logic [127:0] bv, input int n, input int cpos,
                              input logic [15:0] cx, input logic [2:0] pulse, input fields_t f);
    vec_t        v;
    logic [15:0] c;
    for (int i = 0; i < 16; i++) v.b[i] = (i < n) ? bv[127-8*i -: 8] : 8'h00;
    if (cpos > 0) begin
      c = ref_crc(v.b, 1, cpos - 1) ^ cx;
      v.b[cpos]   = c[15:8];
      v.b[cpos+1] = c[7:0];
    end
    v.n = n; v.pulse = pulse; v.f = f;
    return v;
  endfunction

  // Frame-level reference: index of the terminating byte, its pulse, new fields
  function automatic void model(input logic [7:0] m [16], input fields_t cur,
                                output int e, output logic [2:0] p, output fields_t nf);
    int s, nd, c;
    logic rsp;
    logic [7:0] lb;
    s = 0;
    while (s < 15 && m[s] != 8'hFE) s++;
    nf = cur;
    if (m[s+1] == 8'h80) begin
      e = s + 2;
      if (m[s+2] == 8'h7F) begin p = 3'b100; nf.ttype = 3'd4; nf.lse = 8'h80; end
      else p = 3'b001;
    end else if (m[s+1] == 8'h04 || m[s+1] == 8'h05) begin
      rsp = (m[s+1] == 8'h04);
      lb  = m[s+3];
      nd  = (rsp || lb[7]) ? int'(lb[6:0]) : 0;
      if (nd > 3) begin e = s + 3; p = 3'b001; end
      else begin
        c = s + 4 + nd;
        if (m[c+2] != 8'hFE)      begin e = c + 2; p = 3'b001; end
        else if (m[c+3] != 8'h40) begin e = c + 3; p = 3'b001; end
        else begin
          e = c + 3;
          if (ref_crc(m, s + 1, s + 3 + nd) == {m[c], m[c+1]}) begin
            p = 3'b100;
            nf.ttype = rsp ? 3'd3 : 3'd2;
            nf.addr  = m[s+2];
            nf.rw    = lb[7];
            nf.len   = lb[6:0];
            nf.data  = '0;
            for (int q = 0; q < nd; q++) nf.data[23-8*q -: 8] = m[s+4+q];
          end else p = 3'b010;
        end
      end
    end else begin
      e = s + 1; p = 3'b001;
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap, input logic [2:0] exp);
    logic [2:0] acc;
    sb.rx_byte  = b;
    sb.rx_valid = 1'b1;
    @(posedge sb_clk); #1;
    sb.rx_valid = 1'b0;
    chk("pulse", {sb.trans_valid, sb.crc_err, sb.parse_err}, exp);
    acc = 3'b000;
    for (int i = 0; i < gap; i++) begin
      @(posedge sb_clk); #1;
      acc |= {sb.trans_valid, sb.crc_err, sb.parse_err};
    end
    if (gap > 0) chk("gap_pulse", acc, 3'b000);
  endtask

  task automatic send_vec(input vec_t v, input int slow_i, input int slow_gap, input int gap);
    for (int i = 0; i < v.n; i++)
      send_byte(v.b[i], (i == slow_i) ? slow_gap : gap, (i == v.n - 1) ? v.pulse : 3'b000);
  endtask

  initial begin
    logic [7:0]  m [16];
    fields_t     nf;
    logic [2:0]  p;
    int          e, k, kind, nd, stx_i, cnt;
    logic [7:0]  lb;
    logic [15:0] c;

    tbl[0] = mk({8'hFE, 8'h80, 8'h7F, 104'h0}, 3, 0, 16'h0, 3'b100,
                {3'd4, 8'h00, 1'b0, 7'd0, 24'h000000, 8'h80});
    tbl[1] = mk({8'hFE, 8'h80, 8'h7E, 104'h0}, 3, 0, 16'h0, 3'b001,
                {3'd4, 8'h00, 1'b0, 7'd0, 24'h000000, 8'h80});
    tbl[2] = mk({8'hFE, 8'h04, 8'h4E, 8'h03, 8'hA1, 8'hB2, 8'hC3, 16'h0, 8'hFE, 8'h40, 40'h0},
                11, 7, 16'h0, 3'b100, {3'd3, 8'h4E, 1'b0, 7'd3, 24'hA1B2C3, 8'h80});
    tbl[3] = mk({8'hFE, 8'h05, 8'h4E, 8'h03, 16'h0, 8'hFE, 8'h40, 64'h0},
                8, 4, 16'h0, 3'b100, {3'd2, 8'h4E, 1'b0, 7'd3, 24'h000000, 8'h80});
    tbl[4] = mk({8'hFE, 8'h05, 8'h4E, 8'h03, 16'h0, 8'hFE, 8'h40, 64'h0},
                8, 4, 16'h0001, 3'b010, {3'd2, 8'h4E, 1'b0, 7'd3, 24'h000000, 8'h80});
    tbl[5] = mk({8'hFE, 8'h04, 8'h4E, 8'h04, 96'h0}, 4, 0, 16'h0, 3'b001,
                {3'd2, 8'h4E, 1'b0, 7'd3, 24'h000000, 8'h80});
    tbl[6] = mk({8'hFE, 8'h05, 8'h12, 8'h82, 8'hDE, 8'hAD, 16'h0, 8'hFE, 8'h40, 48'h0},
                10, 6, 16'h0, 3'b100, {3'd2, 8'h12, 1'b1, 7'd2, 24'hDEAD00, 8'h80});
    tbl[7] = mk({8'hFE, 8'h04, 8'h33, 8'h01, 8'h55, 16'h0, 8'hFE, 8'h41, 56'h0},
                9, 5, 16'h0, 3'b001, {3'd2, 8'h12, 1'b1, 7'd2, 24'hDEAD00, 8'h80});
    tbl[8] = mk({8'h00, 8'h12, 8'hFE, 8'h80, 8'h7F, 88'h0}, 5, 0, 16'h0, 3'b100,
                {3'd4, 8'h12, 1'b1, 7'd2, 24'hDEAD00, 8'h80});
    tbl[9] = mk({8'hFE, 8'h07, 112'h0}, 2, 0, 16'h0, 3'b001,
                {3'd4, 8'h12, 1'b1, 7'd2, 24'hDEAD00, 8'h80});

    rst = 1'b1;
    sb.rx_byte = 8'h00; sb.rx_valid = 1'b0; sb.rx_frame_err = 1'b0; sb.rx_enable = 1'b1;
    repeat (3) @(posedge sb_clk);
    #1 rst = 1'b0;
    chk("reset_state", {sb.trans_valid, sb.crc_err, sb.parse_err, sb.busy, dut_fields()}, 64'h0);

    // Directed vector table, symbols every 10 cycles
    for (int t = 0; t < 10; t++) begin
      send_vec(tbl[t], -1, 0, 9);
      chk($sformatf("fields_vec%0d", t), dut_fields(), tbl[t].f);
      chk($sformatf("busy_vec%0d", t), sb.busy, 1'b0);
    end
    exp_f = tbl[9].f;

    // Timeout: nothing after the address byte
    send_byte(8'hFE, 2, 3'b000);
    send_byte(8'h05, 2, 3'b000);
    send_byte(8'h4E, 0, 3'b000);
    chk("tmo_busy_before", sb.busy, 1'b1);
    cnt = 0;
    while (!sb.parse_err && cnt < 60) begin @(posedge sb_clk); #1; cnt++; end
    chk("tmo_cycles", cnt, 40);
    chk("tmo_busy_after", sb.busy, 1'b0);
    chk("tmo_fields", dut_fields(), exp_f);
    @(posedge sb_clk); #1;

    // A 40-cycle gap is still inside the limit
    send_vec(tbl[3], 2, 39, 2);
    exp_f = tbl[3].f;
    chk("gap40_fields", dut_fields(), exp_f);

    // Frame error with a data byte: byte discarded, parse error
    for (int i = 0; i < 5; i++) send_byte(tbl[2].b[i], 2, 3'b000);
    sb.rx_byte = 8'hB2; sb.rx_valid = 1'b1; sb.rx_frame_err = 1'b1;
    @(posedge sb_clk); #1;
    sb.rx_valid = 1'b0; sb.rx_frame_err = 1'b0;
    chk("ferr_pulse", {sb.trans_valid, sb.crc_err, sb.parse_err}, 3'b001);
    chk("ferr_busy", sb.busy, 1'b0);
    chk("ferr_fields", dut_fields(), exp_f);
    @(posedge sb_clk); #1;

    // Disconnect mid-frame: silent return to idle
    send_byte(8'hFE, 2, 3'b000);
    send_byte(8'h05, 2, 3'b000);
    sb.rx_enable = 1'b0;
    @(posedge sb_clk); #1;
    chk("dis_pulse", {sb.trans_valid, sb.crc_err, sb.parse_err}, 3'b000);
    chk("dis_busy", sb.busy, 1'b0);
    sb.rx_enable = 1'b1;
    send_vec(tbl[0], -1, 0, 3);
    exp_f.ttype = 3'd4; exp_f.lse = 8'h80;
    chk("dis_lt_fields", dut_fields(), exp_f);

    // Asynchronous reset in the middle of AT data
    for (int i = 0; i < 5; i++) send_byte(tbl[2].b[i], 2, 3'b000);
    #3 rst = 1'b1;
    #1 chk("arst_outputs", {sb.trans_valid, sb.crc_err, sb.parse_err, sb.busy, dut_fields()}, 64'h0);
    @(posedge sb_clk); #1 rst = 1'b0;
    exp_f = '0;
    send_vec(tbl[0], -1, 0, 3);
    exp_f.ttype = 3'd4; exp_f.lse = 8'h80;
    chk("arst_lt_fields", dut_fields(), exp_f);

    // Random frames against the reference model
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < 16; i++) m[i] = 8'h00;
      k = 0;
      repeat ($urandom_range(0, 2)) begin m[k] = 8'($urandom_range(0, 253)); k++; end
      m[k] = 8'hFE; k++;
      kind = $urandom_range(0, 6);
      if (kind == 0) begin m[k] = 8'h80; m[k+1] = 8'h7F; end
      else if (kind == 1) begin m[k] = 8'h80; m[k+1] = 8'($urandom_range(0, 255)); end
      else if (kind == 6) m[k] = 8'($urandom_range(0, 255));
      else begin
        stx_i = k;
        m[k] = (kind == 3 || kind == 4) ? 8'h05 : 8'h04; k++;
        m[k] = 8'($urandom_range(0, 255)); k++;
        nd = 0;
        if (kind == 2)      begin nd = $urandom_range(0, 3); lb = {1'($urandom_range(0, 1)), 7'(nd)}; end
        else if (kind == 3) lb = {1'b0, 7'($urandom_range(0, 127))};
        else if (kind == 4) begin nd = $urandom_range(0, 3); lb = {1'b1, 7'(nd)}; end
        else                lb = {1'($urandom_range(0, 1)), 7'($urandom_range(4, 127))};
        m[k] = lb; k++;
        for (int i = 0; i < nd; i++) begin m[k] = 8'($urandom_range(0, 255)); k++; end
        c = ref_crc(m, stx_i, k - 1);
        if ($urandom_range(0, 3) == 0) c = c ^ (16'h0001 << $urandom_range(0, 15));
        m[k] = c[15:8]; m[k+1] = c[7:0];
        m[k+2] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'hFE;
        m[k+3] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'h40;
      end
      model(m, exp_f, e, p, nf);
      for (int i = 0; i <= e; i++)
        send_byte(m[i], $urandom_range(1, 12), (i == e) ? p : 3'b000);
      exp_f = nf;
      chk($sformatf("rand%0d_fields", f), dut_fields(), exp_f);
      chk($sformatf("rand%0d_busy", f), sb.busy, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sb_trans_receiver_fsm.md
Name: sb_trans_receiver_fsm

Overview:
Sideband (SB) receive-side transaction parser. It consumes byte-level symbols from the SBRX deserializer, one strobe per 10-bit symbol. It recognises LT (DLE-LSE-CLSE) and AT (DLE-STX-addr-len-data-CRC-DLE-ETX) transactions, checks CRC-16 and framing, and reports decoded fields to the control unit. It is the receive counterpart of the SB transaction generator. Its trans_type encoding matches the generator's trans_sel.

Parameters:
TIMEOUT_CYCLES, 40, max sb_clk cycles between consecutive rx_valid strobes inside a transaction before abort
MAX_DATA_BYTES, 3, max AT data bytes captured; any larger length is a parse error

Ports:
sb_clk  in  1  SB clock
rst  in  1  reset; asynchronous, active-high
rx_byte  in  8  received symbol payload (start/stop bits already stripped)
rx_valid  in  1  one-cycle strobe: rx_byte is valid
rx_frame_err  in  1  one-cycle strobe: deserializer saw a bad start/stop bit
rx_enable  in  1  0 = link disconnected; FSM is held in IDLE and input is ignored
trans_type  out  3  last good transaction: 2 = AT command, 3 = AT response, 4 = LT, 0 = none
trans_valid  out  1  one-cycle pulse: good transaction decoded, fields updated
at_addr  out  8  AT address byte
at_rw  out  1  length byte bit7 (1 = write)
at_len  out  7  length byte bits [6:0]
at_data  out  24  data bytes; first byte in [23:16]; unused bytes zero
lt_lse  out  8  received LSE symbol
crc_err  out  1  one-cycle pulse: AT CRC mismatch
parse_err  out  1  one-cycle pulse: framing, sequence, CLSE or timeout error
busy  out  1  FSM not in IDLE

Behaviour:
- Reset: every output 0. FSM goes to IDLE; CRC, byte counter and timeout counter are cleared. Reset mid-transaction discards the transaction and raises no error pulse.
- Symbols: DLE = 0xFE, STX_CMD = 0x05, STX_RSP = 0x04, LSE = 0x80, ETX = 0x40. No DLE stuffing; 0xFE inside the payload is data.
- A byte is accepted only in cycles where rx_valid = 1 and rx_enable = 1.
- Transitions from IDLE and DLE1:
  - IDLE: DLE -> DLE1; any other byte is silently ignored.
  - DLE1: STX_CMD or STX_RSP -> AT_ADDR; record cmd/rsp; CRC initialised to 0xFFFF, then the STX byte is folded in.
  - DLE1: LSE -> LT_CLSE; store the byte.
  - DLE1: any other byte -> parse_err, IDLE.
- LT_CLSE: byte == ~stored LSE -> update lt_lse, trans_type = 4, pulse trans_valid. Otherwise pulse parse_err. Both cases return to IDLE.
- AT_ADDR: store the address byte and fold it into the CRC -> AT_LEN.
- AT_LEN: store rw and len; fold into CRC. Set the expected data count N:
  - N = len for a response, or for a command with rw = 1.
  - N = 0 for a command with rw = 0.
  - N > MAX_DATA_BYTES -> parse_err, IDLE.
  - N = 0 -> CRC_HI; otherwise -> AT_DATA.
- AT_DATA: store byte k into at_data[23-8k -: 8] of a shadow register and fold it into the CRC. After N bytes -> CRC_HI.
- CRC_HI, then CRC_LO: capture the received CRC, high byte first. These bytes are not folded into the CRC.
- DLE2: byte must be DLE, else parse_err, IDLE.
- ETX: byte must be ETX, else parse_err, IDLE. On a valid ETX:
  - CRC match: copy shadow fields to the outputs; trans_type = 2 (cmd) or 3 (rsp); pulse trans_valid.
  - CRC mismatch: pulse crc_err; outputs unchanged.
  - Either way, return to IDLE.
- CRC: CRC-16, polynomial 0x8005, init 0xFFFF, bytes MSB-first, no reflection, no final XOR. Covers STX through the last data byte. One byte is processed per accepted byte, combinationally, so there are no extra cycles.
- Latency: pulses are registered and assert the cycle after the final byte's rx_valid.
- Output hold: field outputs change only on trans_valid and hold otherwise. Pulses last exactly 1 cycle.
- rx_frame_err: outside IDLE -> parse_err, IDLE. In IDLE -> ignored.
  - rx_frame_err wins over a simultaneous rx_valid; that byte is discarded.
- Timeout: the counter resets on each accepted byte and counts only outside IDLE. Reaching TIMEOUT_CYCLES -> parse_err, IDLE.
- rx_enable = 0: immediate return to IDLE; no pulses; field outputs retained.
- busy = (state != IDLE), registered.

Test Plan:
- LT: bytes FE,80,7F at 10-cycle spacing -> one cycle after the 7F strobe: trans_valid = 1, trans_type = 4, lt_lse = 0x80; no error pulses.
- LT bad complement: FE,80,7E -> parse_err pulse; trans_valid stays 0; trans_type keeps its previous value.
- AT response: FE,04,4E,03,A1,B2,C3,CRChi,CRClo,FE,40 with CRC from the bench model -> trans_valid; trans_type = 3, at_addr = 0x4E, at_rw = 0, at_len = 3, at_data = 0xA1B2C3.
- AT command read: FE,05,4E,03,CRC,FE,40 -> trans_type = 2, at_len = 3, no data bytes consumed. Same frame with the CRC low byte XOR 0x01 -> crc_err pulse; all outputs unchanged.
- Errors: length byte 0x04 on a response -> parse_err at the length byte. A 41-cycle gap after the addr byte -> parse_err, busy falls. rx_frame_err together with rx_valid during AT_DATA -> parse_err, byte dropped.
- Reset: assert rst asynchronously mid-AT_DATA -> all outputs 0 immediately, busy = 0. The next complete LT frame decodes correctly.
